// File: rtl/ghash_pkg.sv
// Shared constants and helpers for the GHASH stage-3 result path.
package ghash_pkg;

  localparam int NB_BLOCK_DEF = 128;
  localparam int N_STAGES_MAX = 8;

  // Ceiling log2; clog2(1) is 0, so callers sizing a 0..N count pass N+1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ghash_pipe_slot.sv
// One pipeline register slot: data plus valid bit. Loads in one cycle when enabled and holds otherwise.
// A clear drops the valid bit but keeps the data, and reset zeroes both.
module ghash_pipe_slot #(
  parameter int NB_DATA = 256
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               load,
  input  logic               clear,
  input  logic               prev_vld,
  input  logic [NB_DATA-1:0] prev_dat,
  output logic               slot_vld,
  output logic [NB_DATA-1:0] slot_dat
);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      slot_vld <= 1'b0;
      slot_dat <= '0;
    end else if (clear) begin
      slot_vld <= 1'b0;
    end else if (load) begin
      slot_vld <= prev_vld;
      // A bubble moving in leaves the old data in place.
      if (prev_vld) begin
        slot_dat <= prev_dat;
      end
    end
  end

endmodule

// File: rtl/ghash_elastic_pipe.sv
// Elastic N_STAGES-slot pipe for mod_prod/feedback. Latency is N_STAGES cycles and throughput is 1 word/cycle.
// Backpressure: the ready chain is combinational from i_ready, bubbles collapse, and flush drops all in-flight words.
module ghash_elastic_pipe
  import ghash_pkg::*;
#(
  parameter int NB_BLOCK = NB_BLOCK_DEF,
  parameter int N_STAGES = 2,
  parameter int NB_COUNT = clog2(N_STAGES + 1)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_flush,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [NB_BLOCK-1:0] i_mod_prod,
  input  logic [NB_BLOCK-1:0] i_feedback,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [NB_BLOCK-1:0] o_mod_prod,
  output logic [NB_BLOCK-1:0] o_feedback,
  output logic [NB_COUNT-1:0] o_count
);

  localparam int NB_DATA = 2 * NB_BLOCK;

  logic [N_STAGES:0]                  rdy;
  logic [N_STAGES-1:0]                slot_vld;
  logic [N_STAGES-1:0][NB_DATA-1:0]   slot_dat;
  logic                               in_fire;
  logic                               out_fire;
  logic [NB_COUNT-1:0]                count;

  // A slot can move when it is empty or everything ahead of it can move.
  always_comb begin
    rdy           = '0;
    rdy[N_STAGES] = i_ready;
    for (int k = N_STAGES - 1; k >= 0; k--) begin
      rdy[k] = ~slot_vld[k] | rdy[k+1];
    end
  end

  for (genvar k = 0; k < N_STAGES; k++) begin : g_slot
    logic               prev_vld;
    logic [NB_DATA-1:0] prev_dat;

    if (k == 0) begin : g_head
      assign prev_vld = i_valid & ~i_flush;
      assign prev_dat = {i_mod_prod, i_feedback};
    end else begin : g_body
      assign prev_vld = slot_vld[k-1];
      assign prev_dat = slot_dat[k-1];
    end

    ghash_pipe_slot #(
      .NB_DATA (NB_DATA)
    ) u_slot (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .load     (rdy[k]),
      .clear    (i_flush),
      .prev_vld (prev_vld),
      .prev_dat (prev_dat),
      .slot_vld (slot_vld[k]),
      .slot_dat (slot_dat[k])
    );
  end

  assign o_ready                  = rdy[0] & ~i_flush;
  assign o_valid                  = slot_vld[N_STAGES-1];
  assign {o_mod_prod, o_feedback} = slot_dat[N_STAGES-1];

  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  // Tracks popcount of slot_vld without an adder tree across the slots.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      count <= '0;
    end else if (in_fire && !out_fire) begin
      count <= count + NB_COUNT'(1);
    end else if (!in_fire && out_fire) begin
      count <= count - NB_COUNT'(1);
    end
  end

  assign o_count = count;

endmodule

// File: tb/tb_ghash_elastic_pipe.sv
// Scoreboard bench for ghash_elastic_pipe across several N_STAGES values.
module tb_ghash_elastic_pipe;
  import ghash_pkg::*;

  localparam int NB = 128;
  localparam int NI = 5;
  localparam int NS [NI] = '{2, 4, 1, 3, 8};

  logic          clk = 1'b0;
  logic          rst;
  logic          valid  [NI];
  logic          ready  [NI];
  logic          flush  [NI];
  logic          oready [NI];
  logic          ovalid [NI];
  logic [NB-1:0] mp     [NI];
  logic [NB-1:0] fb     [NI];
  logic [NB-1:0] omp    [NI];
  logic [NB-1:0] ofb    [NI];
  logic [3:0]    ocnt   [NI];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int N  = NS[g];
    localparam int NC = clog2(N + 1);
    logic [NC-1:0] cnt;
    logic [255:0]  q [$];

    ghash_elastic_pipe #(
      .NB_BLOCK (NB),
      .N_STAGES (N)
    ) dut (
      .i_clock    (clk),
      .i_reset    (rst),
      .i_flush    (flush[g]),
      .i_valid    (valid[g]),
      .o_ready    (oready[g]),
      .i_mod_prod (mp[g]),
      .i_feedback (fb[g]),
      .o_valid    (ovalid[g]),
      .i_ready    (ready[g]),
      .o_mod_prod (omp[g]),
      .o_feedback (ofb[g]),
      .o_count    (cnt)
    );

    assign ocnt[g] = 4'(cnt);

    always @(negedge clk) begin
      if (rst) begin
        q.delete();
      end else begin
        check($sformatf("cnt_n%0d", N), 256'(ocnt[g]), 256'(q.size()));
        check($sformatf("rdy_n%0d", N), 256'(oready[g]),
              256'(((q.size() < N) || ready[g]) && !flush[g]));
        if (ovalid[g]) begin
          if (q.size() == 0)
            check($sformatf("spurious_n%0d", N), 256'(ovalid[g]), 256'(0));
          else
            check($sformatf("data_n%0d", N), {omp[g], ofb[g]}, q[0]);
        end
        if (ovalid[g] && ready[g] && q.size() > 0) void'(q.pop_front());
        if (valid[g] && oready[g]) q.push_back({mp[g], fb[g]});
        if (flush[g]) q.delete();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int cnt_lat [8] = '{0, 1, 2, 2, 2, 1, 0, 0};

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      valid[i] = 1'b1;
      ready[i] = 1'b1;
      flush[i] = 1'b0;
      mp[i]    = {32{4'hA}};
      fb[i]    = {32{4'hA}};
    end

    // Reset held two cycles with input offered
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_vld", 256'(ovalid[i]), 256'(0));
      check("rst_mp",  256'(omp[i]),    256'(0));
      check("rst_fb",  256'(ofb[i]),    256'(0));
      check("rst_cnt", 256'(ocnt[i]),   256'(0));
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < NI; i++) valid[i] = 1'b0;

    // Latency and throughput, N=2
    ready[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      valid[0] = (c < 4);
      mp[0]    = NB'(c + 1);
      fb[0]    = ~NB'(c + 1);
      @(negedge clk);
      check("lat_vld", 256'(ovalid[0]), 256'((c >= 2) && (c <= 5)));
      if ((c >= 2) && (c <= 5)) check("lat_mp", 256'(omp[0]), 256'(c - 1));
      check("lat_cnt", 256'(ocnt[0]), 256'(cnt_lat[c]));
      step();
    end

    // Backpressure, N=2
    ready[0] = 1'b0;
    valid[0] = 1'b1;
    mp[0] = NB'(5); fb[0] = NB'(50);
    step();
    mp[0] = NB'(6); fb[0] = NB'(60);
    step();
    mp[0] = NB'(7); fb[0] = NB'(70);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_rdy", 256'(oready[0]), 256'(0));
      check("bp_cnt", 256'(ocnt[0]),   256'(2));
      check("bp_vld", 256'(ovalid[0]), 256'(1));
      check("bp_mp",  256'(omp[0]),    256'(5));
      step();
    end
    valid[0] = 1'b0;
    ready[0] = 1'b1;
    @(negedge clk);
    check("bp_out5", 256'(omp[0]), 256'(5));
    step();
    @(negedge clk);
    check("bp_out6", 256'(omp[0]), 256'(6));
    check("bp_v6",   256'(ovalid[0]), 256'(1));
    step();
    @(negedge clk);
    check("bp_empty", 256'(ovalid[0]), 256'(0));
    step();

    // Bubble collapse, N=4
    ready[1] = 1'b0;
    valid[1] = 1'b1;
    mp[1] = NB'(8'h11); fb[1] = NB'(8'hE1);
    step();
    valid[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bub_cnt", 256'(ocnt[1]),   256'(1));
      check("bub_vld", 256'(ovalid[1]), 256'(c == 3));
      step();
    end
    check("bub_mp", 256'(omp[1]), 256'(8'h11));
    for (int w = 0; w < 3; w++) begin
      valid[1] = 1'b1;
      mp[1] = NB'(8'h12 + w);
      fb[1] = NB'(8'hE2 + w);
      @(negedge clk);
      check("bub_rdy1", 256'(oready[1]), 256'(1));
      step();
    end
    valid[1] = 1'b0;
    @(negedge clk);
    check("bub_rdy0", 256'(oready[1]), 256'(0));
    check("bub_full", 256'(ocnt[1]),   256'(4));
    ready[1] = 1'b1;
    for (int t = 0; t < 20 && ocnt[1] != 0; t++) step();
    check("bub_drain", 256'(ocnt[1]), 256'(0));

    // Flush with three words in flight, N=4
    step();
    ready[1] = 1'b0;
    for (int w = 0; w < 3; w++) begin
      valid[1] = 1'b1;
      mp[1] = NB'(8'h21 + w);
      fb[1] = NB'(8'hD1 + w);
      step();
    end
    flush[1] = 1'b1;
    mp[1] = NB'(8'h99);
    fb[1] = NB'(8'h99);
    @(negedge clk);
    check("fl_rdy", 256'(oready[1]), 256'(0));
    step();
    flush[1] = 1'b0;
    valid[1] = 1'b0;
    @(negedge clk);
    check("fl_vld", 256'(ovalid[1]), 256'(0));
    check("fl_cnt", 256'(ocnt[1]),   256'(0));
    ready[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      @(negedge clk);
      check("fl_quiet", 256'(ovalid[1]), 256'(0));
    end
    step();

    // Reset mid-stream overrides flush and handshakes, N=3
    ready[3] = 1'b0;
    valid[3] = 1'b1;
    for (int w = 0; w < 3; w++) begin
      mp[3] = NB'(8'h40 + w);
      fb[3] = NB'(8'hC0 + w);
      step();
    end
    rst = 1'b1;
    flush[3] = 1'b1;
    step();
    rst = 1'b0;
    flush[3] = 1'b0;
    valid[3] = 1'b0;
    ready[3] = 1'b1;
    @(negedge clk);
    check("mrst_vld", 256'(ovalid[3]), 256'(0));
    check("mrst_mp",  256'(omp[3]),    256'(0));
    check("mrst_cnt", 256'(ocnt[3]),   256'(0));
    step();

    // Randomised traffic on N=1,3,8
    for (int c = 0; c < 1500; c++) begin
      for (int i = 2; i < NI; i++) begin
        valid[i] = ($urandom_range(3) != 0);
        ready[i] = ($urandom_range(2) != 0);
        flush[i] = ($urandom_range(39) == 0);
        mp[i]    = {$urandom(), $urandom(), $urandom(), $urandom()};
        fb[i]    = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      step();
    end
    for (int i = 0; i < NI; i++) begin
      valid[i] = 1'b0;
      flush[i] = 1'b0;
      ready[i] = 1'b1;
    end
    for (int c = 0; c < 12; c++) step();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("end_cnt", 256'(ocnt[i]),   256'(0));
      check("end_vld", 256'(ovalid[i]), 256'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ghash_elastic_pipe.md
Name: ghash_elastic_pipe

Overview:
- Parametrised, back-pressurable pipeline for the GHASH core's stage-3 result path.
- Carries the reduced product (mod_prod) and the accumulator feedback word through N_STAGES register slots.
- Each slot has its own valid bit and a valid/ready handshake, so downstream stalls do not lose data and bubbles collapse.
- Adds a synchronous flush for message boundaries and an occupancy count for the GHASH controller.

Parameters:
- NB_BLOCK, 128, width of one GF(2^128) block.
- N_STAGES, 2, number of register slots; legal range 1..8.
- NB_COUNT, clog2(N_STAGES+1), width of the occupancy count.

Ports:
- i_clock  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_flush  in  1  synchronous flush; drops all in-flight words.
- i_valid  in  1  upstream word present.
- o_ready  out  1  pipe accepts a word this cycle.
- i_mod_prod  in  NB_BLOCK  reduced product in.
- i_feedback  in  NB_BLOCK  feedback word in.
- o_valid  out  1  valid bit of the last slot.
- i_ready  in  1  downstream accepts.
- o_mod_prod  out  NB_BLOCK  last-slot product.
- o_feedback  out  NB_BLOCK  last-slot feedback.
- o_count  out  NB_COUNT  number of valid slots.

Behaviour:
- Reset (i_reset=1 at an edge): all slot valid bits = 0; all slot data = 0; o_count = 0.
  - Next cycle: o_valid=0, o_mod_prod=0, o_feedback=0, o_count=0.
  - Reset mid-stream discards everything and overrides i_flush and all handshakes.
- Slot chain 0..N_STAGES-1; slot N_STAGES-1 drives the outputs.
- Ready chain (combinational):
  - rdy[N_STAGES] = i_ready.
  - rdy[k] = ~v[k] | rdy[k+1].
  - o_ready = rdy[0] & ~i_flush.
  - o_ready therefore depends combinationally on i_ready; accepted, no registered skid.
- Slot load rule for k>0: when rdy[k]=1 the slot takes data and valid from slot k-1.
  - Valid-in = v[k-1].
  - Data is written only when v[k-1]=1; otherwise data holds and v[k] becomes 0.
- Slot 0 loads from the inputs when rdy[0]=1, with valid-in = i_valid & ~i_flush.
- When rdy[k]=0, the slot holds its data and valid bit.
- Fire definitions: in_fire = i_valid & o_ready; out_fire = o_valid & i_ready.
- Latency, empty pipe with i_ready held 1: a word accepted at edge t appears on o_valid after edge t+N_STAGES-1, i.e. N_STAGES cycles input-to-output.
- Throughput: 1 word/cycle while i_ready=1.
- Stall: i_ready=0 with all slots valid gives o_ready=0 and outputs held stable.
- Bubble collapse: with i_ready=0, a word advances into any empty slot ahead of it.
- Flush (i_flush=1, i_reset=0):
  - All valid bits cleared at the edge; data registers hold their values.
  - o_count -> 0.
  - Any input presented in the same cycle is dropped (o_ready=0).
  - out_fire in the flush cycle is still a legal handshake: downstream may consume that word.
- Count update: o_count <= o_count + in_fire - out_fire.
  - Simultaneous in_fire and out_fire leaves the count unchanged.
  - Invariant: o_count == popcount(v). Must never exceed N_STAGES or underflow.
- Data values are passed bit-exact; no arithmetic on the datapath.

Decomposition:
- ghash_pkg holds:
  - NB_BLOCK default constant.
  - clog2 function used for NB_COUNT.
  - N_STAGES_MAX = 8.
- One sub-module, ghash_pipe_slot:
  - 2*NB_BLOCK data register plus valid bit.
  - Inputs: load enable, valid-in, data-in, clear.
  - Instantiated N_STAGES times via generate.
- Ready chain and count logic live in the top module.

Test Plan:
- Reset: drive i_reset=1 for 2 cycles with i_valid=1 and data 0xAA..A -> o_valid=0, o_mod_prod=0, o_feedback=0, o_count=0, nothing accepted.
- Latency/throughput: N_STAGES=2, i_ready=1, stream mod_prod=1,2,3,4 on consecutive cycles -> o_valid rises 2 cycles after the first accept; outputs 1,2,3,4 back-to-back; o_count stays 2 in steady state.
- Backpressure: fill with 5,6, hold i_ready=0 for 4 cycles -> o_ready=0, o_count=2, output holds 5. Release -> 5 then 6 emitted, no loss, no duplication.
- Bubble collapse: N_STAGES=4, i_ready=0, inject one word 0x11 -> it reaches the last slot after 4 cycles; o_count=1; o_ready stays 1 until 4 words are held.
- Flush: 3 words in flight in N_STAGES=4, assert i_flush with i_valid=1 and data 0x99 -> next cycle o_valid=0, o_count=0; 0x99 is never emitted.
- Randomised valid/ready with N_STAGES in {1,3,8}, checked against a scoreboard FIFO -> order preserved, o_count == popcount(valid bits) every cycle.
